// File: rtl/cpu_pkg.sv
// Shared definitions for the multi-cycle 8-bit CPU control unit:
// opcodes, ALU op codes, FSM state encoding and instruction field positions.
package cpu_pkg;

  localparam logic [3:0] OP_LOAD = 4'b1000;
  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_INC  = 4'b1010;
  localparam logic [3:0] OP_DEC  = 4'b1011;
  localparam logic [3:0] OP_JMP  = 4'b1111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    RD_A   = 3'd3,
    RD_B   = 3'd4,
    EXEC   = 3'd5,
    WB     = 3'd6
  } state_t;

  localparam int OP_MSB  = 15;
  localparam int OP_LSB  = 12;
  localparam int RD_MSB  = 9;
  localparam int RD_LSB  = 8;
  localparam int RS1_MSB = 5;
  localparam int RS1_LSB = 4;
  localparam int RS2_MSB = 1;
  localparam int RS2_LSB = 0;
  localparam int IMM_MSB = 7;
  localparam int IMM_LSB = 0;

endpackage

// File: rtl/cpu_decode.sv
// Combinational instruction decoder: classifies the IR contents and
// slices out the register and immediate fields.
module cpu_decode
  import cpu_pkg::*;
(
  input  logic [15:0] ir,
  output logic        is_load,
  output logic        is_alu2,
  output logic        is_incdec,
  output logic        is_jmp,
  output logic        is_illegal,
  output logic [2:0]  alu_op,
  output logic [1:0]  rd,
  output logic [1:0]  rs1,
  output logic [1:0]  rs2,
  output logic [7:0]  imm
);

  logic [3:0] op;
  logic       unused_bits;

  assign op          = ir[OP_MSB:OP_LSB];
  assign rd          = ir[RD_MSB:RD_LSB];
  assign rs1         = ir[RS1_MSB:RS1_LSB];
  assign rs2         = ir[RS2_MSB:RS2_LSB];
  assign imm         = ir[IMM_MSB:IMM_LSB];
  assign unused_bits = ^ir[11:10];

  // Opcode classification; anything unlisted is an illegal NOP
  always_comb begin
    is_load    = 1'b0;
    is_alu2    = 1'b0;
    is_incdec  = 1'b0;
    is_jmp     = 1'b0;
    is_illegal = 1'b0;
    alu_op     = ALU_ADD;
    case (op)
      OP_LOAD: is_load = 1'b1;
      OP_ADD:  is_alu2 = 1'b1;
      OP_SUB: begin
        is_alu2 = 1'b1;
        alu_op  = ALU_SUB;
      end
      OP_INC:  is_incdec = 1'b1;
      OP_DEC: begin
        is_incdec = 1'b1;
        alu_op    = ALU_SUB;
      end
      OP_JMP:  is_jmp = 1'b1;
      default: is_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/cpu_control.sv
// Multi-cycle control unit: sequences fetch, decode, operand read, execute
// and write-back, and owns the program counter and ALU operand registers.
module cpu_control
  import cpu_pkg::*;
#(
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  output logic [7:0]  pc,
  output logic        ir_en,
  input  logic [15:0] ir_data,
  output logic [1:0]  reg_addr,
  output logic        reg_rd,
  output logic        reg_wr,
  output logic [7:0]  reg_wdata,
  input  logic [7:0]  reg_rdata,
  output logic [2:0]  alu_op,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  input  logic [7:0]  alu_out,
  output logic        busy,
  output logic        instr_done,
  output logic        illegal
);

  state_t      state_r;
  state_t      state_s;
  logic [15:0] ir_r;
  logic [7:0]  res_r;

  logic        is_load;
  logic        is_alu2;
  logic        is_incdec;
  logic        is_jmp;
  logic        is_illegal;
  logic [2:0]  dec_alu_op;
  logic [1:0]  rd;
  logic [1:0]  rs1;
  logic [1:0]  rs2;
  logic [7:0]  imm;

  cpu_decode u_decode (
    .ir         (ir_r),
    .is_load    (is_load),
    .is_alu2    (is_alu2),
    .is_incdec  (is_incdec),
    .is_jmp     (is_jmp),
    .is_illegal (is_illegal),
    .alu_op     (dec_alu_op),
    .rd         (rd),
    .rs1        (rs1),
    .rs2        (rs2),
    .imm        (imm)
  );

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= IDLE;
    else        state_r <= state_s;
  end

  // Next state and strobes; strobes decode straight from state so that reset drops them at once
  always_comb begin
    state_s    = state_r;
    ir_en      = 1'b0;
    reg_rd     = 1'b0;
    reg_wr     = 1'b0;
    reg_addr   = 2'b00;
    reg_wdata  = 8'h00;
    alu_op     = ALU_ADD;
    instr_done = 1'b0;
    illegal    = 1'b0;
    busy       = (state_r != IDLE);
    case (state_r)
      IDLE: state_s = run ? FETCH : IDLE;
      FETCH: begin
        ir_en   = 1'b1;
        state_s = DECODE;
      end
      DECODE: begin
        if (is_load) begin
          state_s = WB;
        end else if (is_alu2 || is_incdec) begin
          state_s = RD_A;
        end else begin
          instr_done = 1'b1;
          illegal    = is_illegal;
          state_s    = run ? FETCH : IDLE;
        end
      end
      RD_A: begin
        reg_rd   = 1'b1;
        reg_addr = is_incdec ? rd : rs1;
        state_s  = is_incdec ? EXEC : RD_B;
      end
      RD_B: begin
        reg_rd   = 1'b1;
        reg_addr = rs2;
        state_s  = EXEC;
      end
      EXEC: begin
        alu_op  = dec_alu_op;
        state_s = WB;
      end
      WB: begin
        reg_wr     = 1'b1;
        reg_addr   = rd;
        reg_wdata  = is_load ? imm : res_r;
        instr_done = 1'b1;
        state_s    = run ? FETCH : IDLE;
      end
      default: state_s = IDLE;
    endcase
  end

  // Program counter: jump target in DECODE, otherwise advance when an instruction retires
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_PC;
    end else if (state_r == DECODE && is_jmp) begin
      pc <= imm;
    end else if ((state_r == DECODE && is_illegal) || state_r == WB) begin
      pc <= pc + 8'h01;
    end else begin
      pc <= pc;
    end
  end

  // Instruction, operand and result registers; operands are latched before WB so rd may alias a source
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir_r  <= 16'h0000;
      alu_a <= 8'h00;
      alu_b <= 8'h00;
      res_r <= 8'h00;
    end else begin
      case (state_r)
        FETCH: ir_r <= ir_data;
        RD_A: begin
          alu_a <= reg_rdata;
          if (is_incdec) alu_b <= 8'h01;
          else           alu_b <= alu_b;
        end
        RD_B: alu_b <= reg_rdata;
        EXEC: res_r <= alu_out;
        default: begin
          ir_r  <= ir_r;
          alu_a <= alu_a;
          alu_b <= alu_b;
          res_r <= res_r;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_control.sv
// Self-checking bench for cpu_control: an instruction-level model expands each
// fetched instruction into its expected per-cycle outputs and is compared every cycle.
module tb_cpu_control;

  localparam logic [7:0] RESET_PC = 8'h00;
  localparam int T_IDLE = 0, T_FETCH = 1, T_DEC = 2, T_RDA = 3, T_RDB = 4, T_EXEC = 5, T_WB = 6;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        run;
  logic [7:0]  pc;
  logic        ir_en;
  logic [15:0] ir_data;
  logic [1:0]  reg_addr;
  logic        reg_rd;
  logic        reg_wr;
  logic [7:0]  reg_wdata;
  logic [7:0]  reg_rdata;
  logic [2:0]  alu_op;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic [7:0]  alu_out;
  logic        busy;
  logic        instr_done;
  logic        illegal;

  logic [15:0] imem [256];
  logic [7:0]  rf  [4] = '{default: 8'h00};
  logic [7:0]  mrf [4] = '{default: 8'h00};

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       ir_en, reg_rd, reg_wr, done, ill;
    logic [1:0] addr;
    logic [7:0] wdata, a, b, pc, npc;
    logic [2:0] aop;
    int         tag;
  } rec_t;

  rec_t       q[$];
  logic [7:0] mpc = RESET_PC;
  logic [7:0] ma = 8'h00;
  logic [7:0] mb = 8'h00;
  int         m_done = 0;
  int         cur_tag = T_IDLE;

  cpu_control #(.RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .pc(pc), .ir_en(ir_en), .ir_data(ir_data),
    .reg_addr(reg_addr), .reg_rd(reg_rd), .reg_wr(reg_wr), .reg_wdata(reg_wdata),
    .reg_rdata(reg_rdata), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_out(alu_out), .busy(busy), .instr_done(instr_done), .illegal(illegal)
  );

  always #5 clk = ~clk;

  // Environment: instruction memory, register file and ALU
  assign ir_data   = ir_en ? imem[pc] : 16'h0000;
  assign reg_rdata = rf[reg_addr];
  assign alu_out   = (alu_op == 3'b001) ? (alu_a - alu_b) : (alu_a + alu_b);

  always @(posedge clk) begin
    if (reg_wr) rf[reg_addr] <= reg_wdata;
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic rec_t blank(input logic [7:0] a);
    rec_t r;
    r.ir_en = 1'b0; r.reg_rd = 1'b0; r.reg_wr = 1'b0; r.done = 1'b0; r.ill = 1'b0;
    r.addr = 2'b00; r.wdata = 8'h00; r.a = ma; r.b = mb; r.pc = a; r.npc = a;
    r.aop = 3'b000; r.tag = T_IDLE;
    return r;
  endfunction

  // Expand the instruction at address a into its cycle-by-cycle expected outputs
  task automatic build(input logic [7:0] a);
    rec_t        r;
    logic [15:0] w;
    logic [3:0]  op;
    logic [1:0]  rd, rs1, rs2, src;
    logic [7:0]  imm, res;
    logic        two, sub;
    w = imem[a]; op = w[15:12]; rd = w[9:8]; rs1 = w[5:4]; rs2 = w[1:0]; imm = w[7:0];
    r = blank(a); r.ir_en = 1'b1; r.tag = T_FETCH; q.push_back(r);
    r = blank(a); r.tag = T_DEC;
    if (op == 4'h8) begin
      q.push_back(r);
      r = blank(a); r.tag = T_WB; r.reg_wr = 1'b1; r.addr = rd; r.wdata = imm;
      r.done = 1'b1; r.npc = a + 8'h01; q.push_back(r);
    end else if (op == 4'h0 || op == 4'h1 || op == 4'hA || op == 4'hB) begin
      q.push_back(r);
      two = (op == 4'h0 || op == 4'h1);
      sub = (op == 4'h1 || op == 4'hB);
      src = two ? rs1 : rd;
      r = blank(a); r.tag = T_RDA; r.reg_rd = 1'b1; r.addr = src; q.push_back(r);
      ma = mrf[src];
      if (two) begin
        r = blank(a); r.tag = T_RDB; r.reg_rd = 1'b1; r.addr = rs2; q.push_back(r);
        mb = mrf[rs2];
      end else begin
        mb = 8'h01;
      end
      res = sub ? (ma - mb) : (ma + mb);
      r = blank(a); r.tag = T_EXEC; r.aop = sub ? 3'b001 : 3'b000; q.push_back(r);
      r = blank(a); r.tag = T_WB; r.reg_wr = 1'b1; r.addr = rd; r.wdata = res;
      r.done = 1'b1; r.npc = a + 8'h01; q.push_back(r);
    end else if (op == 4'hF) begin
      r.done = 1'b1; r.npc = imm; q.push_back(r);
    end else begin
      r.done = 1'b1; r.ill = 1'b1; r.npc = a + 8'h01; q.push_back(r);
    end
  endtask

  // Per-cycle comparison against the model, sampled on the falling edge
  always @(negedge clk) begin
    rec_t e;
    logic busy_e;
    logic nb;
    nb = 1'b0;
    if (!rst_n) begin
      q.delete(); mpc = RESET_PC; ma = 8'h00; mb = 8'h00;
      e = blank(RESET_PC); busy_e = 1'b0; cur_tag = T_IDLE;
    end else if (q.size() == 0) begin
      e = blank(mpc); busy_e = 1'b0; cur_tag = T_IDLE; nb = run;
    end else begin
      e = q.pop_front(); busy_e = 1'b1; cur_tag = e.tag;
      if (e.reg_wr) mrf[e.addr] = e.wdata;
      if (e.done) begin
        mpc = e.npc; m_done++; nb = run;
      end
    end
    chk("pc", 16'(pc), 16'(e.pc));
    chk("ir_en", 16'(ir_en), 16'(e.ir_en));
    chk("reg_rd", 16'(reg_rd), 16'(e.reg_rd));
    chk("reg_wr", 16'(reg_wr), 16'(e.reg_wr));
    chk("reg_addr", 16'(reg_addr), 16'(e.addr));
    chk("reg_wdata", 16'(reg_wdata), 16'(e.wdata));
    chk("alu_op", 16'(alu_op), 16'(e.aop));
    chk("alu_a", 16'(alu_a), 16'(e.a));
    chk("alu_b", 16'(alu_b), 16'(e.b));
    chk("busy", 16'(busy), 16'(busy_e));
    chk("instr_done", 16'(instr_done), 16'(e.done));
    chk("illegal", 16'(illegal), 16'(e.ill));
    if (nb) build(mpc);
  end

  task automatic wait_done(input int n);
    int k;
    k = 0;
    do begin
      @(negedge clk); #1; k++;
    end while (m_done < n && k < 400);
    if (m_done < n) begin
      checks++; errors++;
      $display("FAIL wait_done actual=%0d required=%0d", m_done, n);
    end
  endtask

  task automatic wait_tag(input int t);
    int k;
    k = 0;
    do begin
      @(negedge clk); #1; k++;
    end while (cur_tag != t && k < 400);
    if (cur_tag != t) begin
      checks++; errors++;
      $display("FAIL wait_tag actual=%0d required=%0d", cur_tag, t);
    end
  endtask

  initial begin
    int cnt;
    for (int i = 0; i < 256; i++) imem[i] = 16'h5000;
    imem[0]  = 16'h8105;  // LOAD R1,5
    imem[1]  = 16'h8003;  // LOAD R0,3
    imem[2]  = 16'h0201;  // ADD R2,R0,R1
    imem[3]  = 16'h1301;  // SUB R3,R0,R1
    imem[4]  = 16'h82FF;  // LOAD R2,FF
    imem[5]  = 16'hA200;  // INC R2
    imem[6]  = 16'h8300;  // LOAD R3,0
    imem[7]  = 16'hB300;  // DEC R3
    imem[8]  = 16'h0111;  // ADD R1,R1,R1
    imem[9]  = 16'hF00C;  // JMP 0C
    imem[10] = 16'h80AA;
    imem[11] = 16'h80AA;
    imem[12] = 16'h7000;  // illegal
    imem[13] = 16'hF0FF;  // JMP FF
    imem[255] = 16'h4000; // illegal, pc wraps to 0

    rst_n = 1'b0; run = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    chk("rst_pc", 16'(pc), 16'h0000);
    chk("rst_busy", 16'(busy), 16'h0000);
    chk("rst_ir_en", 16'(ir_en), 16'h0000);
    @(posedge clk); #2 rst_n = 1'b1;

    repeat (4) @(negedge clk); #1;
    chk("load_wr", 16'(reg_wr), 16'h0001);
    chk("load_addr", 16'(reg_addr), 16'h0001);
    chk("load_wdata", 16'(reg_wdata), 16'h0005);
    chk("load_done", 16'(instr_done), 16'h0001);
    @(negedge clk); #1;
    chk("load_pc", 16'(pc), 16'h0001);

    wait_done(3);
    chk("add_alu_a", 16'(alu_a), 16'h0003);
    chk("add_alu_b", 16'(alu_b), 16'h0005);
    @(posedge clk); #1 chk("add_r2", 16'(rf[2]), 16'h0008);
    wait_done(4);
    @(posedge clk); #1 chk("sub_r3", 16'(rf[3]), 16'h00FE);
    wait_done(6);
    @(posedge clk); #1 chk("inc_r2", 16'(rf[2]), 16'h0000);
    wait_done(8);
    @(posedge clk); #1 chk("dec_r3", 16'(rf[3]), 16'h00FF);
    wait_done(9);
    @(posedge clk); #1 chk("alias_r1", 16'(rf[1]), 16'h000A);
    wait_done(10);
    chk("jmp_no_wr", 16'(reg_wr), 16'h0000);
    @(negedge clk); #1 chk("jmp_pc", 16'(pc), 16'h000C);
    wait_done(13);
    chk("nop_illegal", 16'(illegal), 16'h0001);
    chk("nop_pc_ff", 16'(pc), 16'h00FF);
    @(negedge clk); #1 chk("nop_pc_wrap", 16'(pc), 16'h0000);

    // drop run while the second-pass ADD is reading operands
    wait_tag(T_RDA);
    @(posedge clk); #2 run = 1'b0;
    wait_done(16);
    repeat (4) @(negedge clk); #1;
    chk("stop_busy", 16'(busy), 16'h0000);
    chk("stop_pc", 16'(pc), 16'h0003);
    chk("stop_r2", 16'(rf[2]), 16'h0008);

    // jump-to-self loop
    imem[3] = 16'hF003;
    @(posedge clk); #2 run = 1'b1;
    repeat (10) @(negedge clk);
    cnt = 0;
    repeat (8) begin
      @(negedge clk); #1 cnt += int'(instr_done);
    end
    chk("loop_pulses", 16'(cnt), 16'h0004);
    chk("loop_pc", 16'(pc), 16'h0003);
    @(posedge clk); #2 run = 1'b0;
    repeat (6) @(negedge clk); #1;
    chk("loop_idle", 16'(busy), 16'h0000);

    // reset during EXEC aborts the write
    imem[3] = 16'h0300;  // ADD R3,R0,R0
    @(posedge clk); #2 run = 1'b1;
    wait_tag(T_EXEC);
    rst_n = 1'b0;
    #1;
    chk("abort_wr", 16'(reg_wr), 16'h0000);
    chk("abort_busy", 16'(busy), 16'h0000);
    chk("abort_pc", 16'(pc), 16'(RESET_PC));
    chk("abort_alu_a", 16'(alu_a), 16'h0000);
    chk("abort_alu_b", 16'(alu_b), 16'h0000);
    chk("abort_addr", 16'(reg_addr), 16'h0000);
    chk("abort_alu_op", 16'(alu_op), 16'h0000);
    run = 1'b0;
    repeat (2) @(posedge clk); #1;
    chk("abort_r3", 16'(rf[3]), 16'h00FF);
    @(posedge clk); #2 rst_n = 1'b1;
    repeat (4) @(negedge clk); #1;

    for (int i = 0; i < 4; i++) chk("final_rf", 16'(rf[i]), 16'(mrf[i]));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
